// File: rtl/alu_pkg.sv
// Shared ALU constants and the 32-bit word type.
`timescale 1ns/1ps
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/sll_stage.sv
// One level of the logarithmic left shifter: shifts by SHIFT when enabled.
// With ALU_SLL_LOST_EN defined, also reports whether any set bit fell off the top.
`timescale 1ns/1ps
module sll_stage
  import alu_pkg::*;
#(
  parameter int unsigned SHIFT = 1
) (
  input  logic  en_i,
  input  word_t din_i,
  output word_t dout_o
`ifdef ALU_SLL_LOST_EN
  ,
  output logic  lost_o
`endif
);

  always_comb begin
    dout_o = din_i;
    if (en_i) begin
      dout_o = {din_i[DATA_W-SHIFT-1:0], {SHIFT{1'b0}}};
    end
  end

`ifdef ALU_SLL_LOST_EN
  assign lost_o = en_i & (|din_i[DATA_W-1 -: SHIFT]);
`endif

endmodule

// File: rtl/alu_sll.sv
// Registered 32-bit logical shift-left with one-cycle latency.
// Optional ALU_SLL_LOST_EN adds lost_bits (OR of bits shifted past bit 31).
`timescale 1ns/1ps
module alu_sll
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  word_t              A,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output word_t              out,
  output logic               out_valid
`ifdef ALU_SLL_LOST_EN
  ,
  output logic               lost_bits
`endif
);

  word_t stage_data [SHAMT_W+1];
  word_t out_q;
  logic  out_valid_q;

  assign stage_data[0] = A;

`ifdef ALU_SLL_LOST_EN
  logic [SHAMT_W-1:0] stage_lost;
  logic               lost_d;
  logic               lost_q;
`endif

  // Level k shifts by 2**k under control of shift-amount bit k.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    sll_stage #(
      .SHIFT (1 << k)
    ) u_stage (
      .en_i   (ctrl_shiftamt[k]),
      .din_i  (stage_data[k]),
      .dout_o (stage_data[k+1])
`ifdef ALU_SLL_LOST_EN
      ,
      .lost_o (stage_lost[k])
`endif
    );
  end

`ifdef ALU_SLL_LOST_EN
  // Each original bit is discarded by at most one stage, so OR-ing stages is exact.
  assign lost_d = |stage_lost;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_SLL_LOST_EN
      lost_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q <= stage_data[SHAMT_W];
`ifdef ALU_SLL_LOST_EN
        lost_q <= lost_d;
`endif
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
`ifdef ALU_SLL_LOST_EN
  assign lost_bits = lost_q;
`endif

endmodule

// File: tb/tb_alu_sll.sv
// Directed self-checking bench for alu_sll (lost_bits checked when ALU_SLL_LOST_EN is defined).
`timescale 1ns/1ps
module tb_alu_sll;
  import alu_pkg::*;

  logic               clock;
  logic               reset_n;
  logic               in_valid;
  word_t              A;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  word_t              out;
  logic               out_valid;
`ifdef ALU_SLL_LOST_EN
  logic               lost_bits;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_sll dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .A             (A),
    .ctrl_shiftamt (ctrl_shiftamt),
    .out           (out),
    .out_valid     (out_valid)
`ifdef ALU_SLL_LOST_EN
    ,
    .lost_bits     (lost_bits)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive on the falling edge, sample 1ns after the following rising edge.
  task automatic issue(input word_t a, input logic [4:0] s);
    @(negedge clock);
    in_valid      = 1'b1;
    A             = a;
    ctrl_shiftamt = s;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n       = 1'b0;
    in_valid      = 1'b0;
    A             = '0;
    ctrl_shiftamt = '0;
    #3;
    n_cmp++;
    if (out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_out: got %h want %h", out, 32'h0);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
`ifdef ALU_SLL_LOST_EN
    n_cmp++;
    if (lost_bits !== 1'b0) begin
      n_err++;
      $display("FAIL reset_lost: got %b want 0", lost_bits);
    end
`endif
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_walking_one;
    word_t exp;
    for (int i = 0; i < 32; i++) begin
      issue(32'h1, 5'(i));
      exp = 32'h1 << i;
      n_cmp++;
      if (out !== exp || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL walk_%0d: got out=%h valid=%b want out=%h valid=1", i, out, out_valid, exp);
      end
`ifdef ALU_SLL_LOST_EN
      n_cmp++;
      if (lost_bits !== 1'b0) begin
        n_err++;
        $display("FAIL walk_lost_%0d: got %b want 0", i, lost_bits);
      end
`endif
    end
  endtask

  task automatic test_saturation;
    issue(32'hFFFF_FFFF, 5'd31);
    n_cmp++;
    if (out !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL sat_31: got %h want %h", out, 32'h8000_0000);
    end
`ifdef ALU_SLL_LOST_EN
    n_cmp++;
    if (lost_bits !== 1'b1) begin
      n_err++;
      $display("FAIL sat_31_lost: got %b want 1", lost_bits);
    end
`endif
    issue(32'hFFFF_FFFF, 5'd0);
    n_cmp++;
    if (out !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sat_0: got %h want %h", out, 32'hFFFF_FFFF);
    end
`ifdef ALU_SLL_LOST_EN
    n_cmp++;
    if (lost_bits !== 1'b0) begin
      n_err++;
      $display("FAIL sat_0_lost: got %b want 0", lost_bits);
    end
`endif
  endtask

  // Consecutive requests with distinct results, including one that loses set bits.
  task automatic test_back_to_back;
    issue(32'h1234_5678, 5'd4);
    n_cmp++;
    if (out !== 32'h2345_6780 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pat4: got out=%h valid=%b want %h/1", out, out_valid, 32'h2345_6780);
    end
`ifdef ALU_SLL_LOST_EN
    n_cmp++;
    if (lost_bits !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pat4_lost: got %b want 1", lost_bits);
    end
`endif
    issue(32'h0000_0001, 5'd16);
    n_cmp++;
    if (out !== 32'h0001_0000 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pat16: got out=%h valid=%b want %h/1", out, out_valid, 32'h0001_0000);
    end
`ifdef ALU_SLL_LOST_EN
    n_cmp++;
    if (lost_bits !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_pat16_lost: got %b want 0", lost_bits);
    end
`endif
    issue(32'hF000_0001, 5'd28);
    n_cmp++;
    if (out !== 32'h1000_0000 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pat28: got out=%h valid=%b want %h/1", out, out_valid, 32'h1000_0000);
    end
`ifdef ALU_SLL_LOST_EN
    n_cmp++;
    if (lost_bits !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pat28_lost: got %b want 1", lost_bits);
    end
`endif
  endtask

  task automatic test_hold;
    issue(32'h0000_0001, 5'd8);
    n_cmp++;
    if (out !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL hold_setup: got %h want %h", out, 32'h0000_0100);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid      = 1'b0;
      A             = 32'hDEAD_BEEF ^ word_t'(i);
      ctrl_shiftamt = 5'(i + 3);
      @(posedge clock);
      #1;
      n_cmp++;
      if (out !== 32'h0000_0100 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: got out=%h valid=%b want %h/0", i, out, out_valid, 32'h0000_0100);
      end
    end
  endtask

  task automatic test_reset_midstream;
    issue(32'h0000_00F0, 5'd4);
    n_cmp++;
    if (out !== 32'h0000_0F00) begin
      n_err++;
      $display("FAIL mid_setup: got %h want %h", out, 32'h0000_0F00);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out !== 32'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got out=%h valid=%b want 0/0", out, out_valid);
    end
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    issue(32'h3, 5'd1);
    n_cmp++;
    if (out !== 32'h6 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: got out=%h valid=%b want %h/1", out, out_valid, 32'h6);
    end
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_walking_one();
    test_saturation();
    test_back_to_back();
    test_hold();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
